serial_seq_ctrl: RTL and testbench

//  Sequencer for the single-bit serial detector datapath (input a, output b, clock ck).

---
 rtl/serial_seq_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_serial_seq_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_seq_ctrl.sv
// serial_seq_ctrl
// Shifts a latched parallel pattern MSB-first onto the serial detector input,
// holds a_out low while the detector pipeline drains, counts rising edges of the
// detector output during the run and pulses done once the run is over.
//
// Optional build macro: SEQ_CTRL_LOOP_EN
//   When defined, a start seen in DONE re-runs the already-latched pattern
//   straight away instead of passing through IDLE.
//
// state   | meaning
// S_IDLE  | waiting for start; a_out low, busy low
// S_SHIFT | pattern bits on a_out, MSB first, each held HOLD cycles
// S_DRAIN | a_out low for DET_LAT cycles while the detector output settles
// S_DONE  | one-cycle done pulse; hit_cnt frozen

module serial_seq_ctrl #(
    parameter int WIDTH   = 8,
    parameter int HOLD    = 1,
    parameter int DET_LAT = 2,
    parameter int CNT_W   = 4
) (
    input  logic             ck,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic             b_in,
    output logic             a_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] hit_cnt
);

    localparam int BIT_W  = (WIDTH   > 1) ? $clog2(WIDTH)   : 1;
    localparam int HOLD_W = (HOLD    > 1) ? $clog2(HOLD)    : 1;
    localparam int DRN_W  = (DET_LAT > 1) ? $clog2(DET_LAT) : 1;

    localparam logic [CNT_W-1:0]  HIT_MAX    = '1;
    localparam logic [BIT_W-1:0]  BIT_LOAD   = BIT_W'(WIDTH - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(HOLD - 1);
    localparam logic [DRN_W-1:0]  DRAIN_LOAD = DRN_W'(DET_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q,  state_d;
    logic [WIDTH-1:0]   pat_q,    pat_d;
    logic [BIT_W-1:0]   bit_q,    bit_d;
    logic [HOLD_W-1:0]  hold_q,   hold_d;
    logic [DRN_W-1:0]   drain_q,  drain_d;
    logic               b_prev_q, b_prev_d;
    logic               a_out_q,  a_out_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;
    logic [CNT_W-1:0]   hit_q,    hit_d;

    logic               load;
    logic [WIDTH-1:0]   load_pat;

    // Next-state, counter and registered-output computation.
    // bit_q counts down the remaining bits, hold_q and drain_q are down-counters
    // whose terminal count (zero) ends the current bit or the drain phase.
    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        bit_d    = bit_q;
        hold_d   = hold_q;
        drain_d  = drain_q;
        b_prev_d = b_prev_q;
        a_out_d  = a_out_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        hit_d    = hit_q;
        load     = 1'b0;
        load_pat = pat_q;

        // Edge counting only while the detector is being exercised.
        if ((state_q == S_SHIFT) || (state_q == S_DRAIN)) begin
            b_prev_d = b_in;
            if (b_in && !b_prev_q && (hit_q != HIT_MAX)) begin
                hit_d = hit_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                a_out_d = 1'b0;
                busy_d  = 1'b0;
                if (start) begin
                    load     = 1'b1;
                    load_pat = pattern;
                end
            end

            S_SHIFT: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - 1'b1;
                end else if (bit_q != '0) begin
                    bit_d   = bit_q - 1'b1;
                    hold_d  = HOLD_LOAD;
                    a_out_d = pat_q[bit_q - 1'b1];
                end else begin
                    state_d = S_DRAIN;
                    a_out_d = 1'b0;
                    drain_d = DRAIN_LOAD;
                end
            end

            S_DRAIN: begin
                if (drain_q != '0) begin
                    drain_d = drain_q - 1'b1;
                end else begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
`ifdef SEQ_CTRL_LOOP_EN
                if (start) begin
                    load     = 1'b1;
                    load_pat = pat_q;
                end
`endif
            end

            default: begin
                state_d = S_IDLE;
                a_out_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        // Common entry into SHIFT: first bit goes out on the next cycle, and the
        // edge history starts at 0 so a b_in already high counts as an edge.
        if (load) begin
            state_d  = S_SHIFT;
            pat_d    = load_pat;
            bit_d    = BIT_LOAD;
            hold_d   = HOLD_LOAD;
            a_out_d  = load_pat[WIDTH-1];
            busy_d   = 1'b1;
            hit_d    = '0;
            b_prev_d = 1'b0;
        end
    end

    // State, counters and all outputs are registered; reset aborts any run at once.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pat_q    <= '0;
            bit_q    <= '0;
            hold_q   <= '0;
            drain_q  <= '0;
            b_prev_q <= 1'b0;
            a_out_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hit_q    <= '0;
        end else begin
            state_q  <= state_d;
            pat_q    <= pat_d;
            bit_q    <= bit_d;
            hold_q   <= hold_d;
            drain_q  <= drain_d;
            b_prev_q <= b_prev_d;
            a_out_q  <= a_out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hit_q    <= hit_d;
        end
    end

    assign a_out   = a_out_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign hit_cnt = hit_q;

endmodule

// File: tb/tb_serial_seq_ctrl.sv
// Directed bench for serial_seq_ctrl. Cycle c is the interval after edge c-1,
// where edge 0 is the edge that samples start. Outputs are checked 1 time unit
// after a rising edge; b_in driven in cycle c is sampled at edge c.
// A second instance with HOLD=2 and a 3-bit counter exercises bit holding and
// hit counter saturation (nine rising edges against a maximum of seven).

module tb_serial_seq_ctrl;

    logic       ck;
    logic       rst_n;
    logic       start;
    logic [7:0] pattern;
    logic       b_in;
    logic       a_out;
    logic       busy;
    logic       done;
    logic [3:0] hit_cnt;

    logic       start2;
    logic [7:0] pattern2;
    logic       b2;
    logic       a2;
    logic       busy2;
    logic       done2;
    logic [2:0] hit2;

    int n_assert = 0;
    int n_fail   = 0;

    serial_seq_ctrl #(.WIDTH(8), .HOLD(1), .DET_LAT(2), .CNT_W(4)) u_dut (
        .ck      (ck),
        .rst_n   (rst_n),
        .start   (start),
        .pattern (pattern),
        .b_in    (b_in),
        .a_out   (a_out),
        .busy    (busy),
        .done    (done),
        .hit_cnt (hit_cnt)
    );

    serial_seq_ctrl #(.WIDTH(8), .HOLD(2), .DET_LAT(2), .CNT_W(3)) u_h2 (
        .ck      (ck),
        .rst_n   (rst_n),
        .start   (start2),
        .pattern (pattern2),
        .b_in    (b2),
        .a_out   (a2),
        .busy    (busy2),
        .done    (done2),
        .hit_cnt (hit2)
    );

    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    // One run on the default instance with b_in low. exp_bits bit 7 is the
    // a_out value of cycle 1. start/pattern are re-driven in cycles re_lo..re_hi.
    task automatic check_run(input string name, input logic [7:0] pat,
                             input logic [7:0] exp_bits, input int re_lo,
                             input int re_hi, input logic [7:0] re_pat);
        pattern = pat;
        start   = 1'b1;
        b_in    = 1'b0;
        step();
        start = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            if (c >= re_lo && c <= re_hi) begin
                start   = 1'b1;
                pattern = re_pat;
            end else begin
                start = 1'b0;
            end
            check($sformatf("%s a_out c%0d", name, c), 32'(a_out),
                  (c <= 8) ? 32'(exp_bits[8 - c]) : 32'd0);
            check($sformatf("%s busy c%0d", name, c), 32'(busy), (c <= 10) ? 32'd1 : 32'd0);
            check($sformatf("%s done c%0d", name, c), 32'(done), (c == 11) ? 32'd1 : 32'd0);
            check($sformatf("%s hit c%0d", name, c), 32'(hit_cnt), 32'd0);
            step();
        end
        start = 1'b0;
        for (int c = 12; c <= 14; c++) begin
            check($sformatf("%s done c%0d", name, c), 32'(done), 32'd0);
            check($sformatf("%s busy c%0d", name, c), 32'(busy), 32'd0);
            step();
        end
    endtask

    logic [0:11] ea;
    logic [0:11] eb;
    logic [0:11] ed;
    logic [0:11] bh;
    int          eh [0:11];
    logic [7:0]  pv;

    initial begin
        rst_n    = 1'b1;
        start    = 1'b0;
        pattern  = 8'h00;
        b_in     = 1'b0;
        start2   = 1'b0;
        pattern2 = 8'h00;
        b2       = 1'b0;

        // Reset asserted mid-cycle: outputs must clear before any clock edge.
        step();
        #3;
        rst_n = 1'b0;
        #1;
        check("rst a_out", 32'(a_out), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst hit", 32'(hit_cnt), 32'd0);
        check("rst busy2", 32'(busy2), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Pattern A5 with b_in high in cycles 3,4,6,10: three rising edges.
        ea = 12'b0_10100101_000;
        eb = 12'b0_1111111111_0;
        ed = 12'b0_0000000000_1;
        bh = 12'b000110100010;
        eh = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 2, 2, 3};
        pattern = 8'hA5;
        start   = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            b_in = bh[c];
            check($sformatf("A a_out c%0d", c), 32'(a_out), 32'(ea[c]));
            check($sformatf("A busy c%0d", c), 32'(busy), 32'(eb[c]));
            check($sformatf("A done c%0d", c), 32'(done), 32'(ed[c]));
            check($sformatf("A hit c%0d", c), 32'(hit_cnt), 32'(eh[c]));
            step();
        end
        // b_in edges in IDLE must not count.
        check("A done c12", 32'(done), 32'd0);
        check("A hit c12", 32'(hit_cnt), 32'd3);
        b_in = 1'b1;
        step();
        b_in = 1'b0;
        step();
        b_in = 1'b1;
        step();
        b_in = 1'b0;
        check("A idle hit", 32'(hit_cnt), 32'd3);
        check("A idle a_out", 32'(a_out), 32'd0);
        check("A idle busy", 32'(busy), 32'd0);
        step();

        // start re-asserted with FF mid-run must be ignored; hit clears on start.
        check_run("B", 8'hA5, 8'hA5, 5, 10, 8'hFF);

        // Reset in cycle 4 aborts the run with no done pulse.
        pattern = 8'hA5;
        start   = 1'b1;
        step();
        start = 1'b0;
        step();
        b_in = 1'b1;
        step();
        b_in = 1'b0;
        check("C hit c3", 32'(hit_cnt), 32'd1);
        check("C busy c3", 32'(busy), 32'd1);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("C rst busy", 32'(busy), 32'd0);
        check("C rst a_out", 32'(a_out), 32'd0);
        check("C rst hit", 32'(hit_cnt), 32'd0);
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            check($sformatf("C no done c%0d", c), 32'(done), 32'd0);
            check($sformatf("C no busy c%0d", c), 32'(busy), 32'd0);
            step();
        end
        check_run("D", 8'h81, 8'h81, 0, -1, 8'h00);

        // HOLD=2 instance: bits held two cycles, done on cycle 19, counter saturates.
        pv       = 8'hA5;
        pattern2 = pv;
        start2   = 1'b1;
        step();
        start2 = 1'b0;
        for (int c = 1; c <= 19; c++) begin
            b2 = (c <= 18) ? c[0] : 1'b0;
            check($sformatf("H a_out c%0d", c), 32'(a2),
                  (c <= 16) ? 32'(pv[7 - ((c - 1) / 2)]) : 32'd0);
            check($sformatf("H busy c%0d", c), 32'(busy2), (c <= 18) ? 32'd1 : 32'd0);
            check($sformatf("H done c%0d", c), 32'(done2), (c == 19) ? 32'd1 : 32'd0);
            if (c == 12) check("H hit c12", 32'(hit2), 32'd6);
            if (c == 14) check("H hit c14", 32'(hit2), 32'd7);
            if (c == 19) check("H hit done", 32'(hit2), 32'd7);
            step();
        end
        b2 = 1'b0;
        check("H hit idle", 32'(hit2), 32'd7);
        check("H done c20", 32'(done2), 32'd0);
        step();

        // start held high across DONE.
        pattern = 8'h81;
        start   = 1'b1;
        step();
        for (int c = 1; c <= 11; c++) begin
            if (c == 5) pattern = 8'h00;
            b_in = (c == 9);
            check($sformatf("L done c%0d", c), 32'(done), (c == 11) ? 32'd1 : 32'd0);
            if (c == 1) check("L a_out c1", 32'(a_out), 32'd1);
            if (c == 11) check("L hit c11", 32'(hit_cnt), 32'd1);
            step();
        end
`ifdef SEQ_CTRL_LOOP_EN
        check("L a_out c12", 32'(a_out), 32'd1);
        check("L busy c12", 32'(busy), 32'd1);
        check("L done c12", 32'(done), 32'd0);
        check("L hit c12", 32'(hit_cnt), 32'd0);
`else
        check("L a_out c12", 32'(a_out), 32'd0);
        check("L busy c12", 32'(busy), 32'd0);
        check("L done c12", 32'(done), 32'd0);
        check("L hit c12", 32'(hit_cnt), 32'd1);
        step();
        check("L busy c13", 32'(busy), 32'd1);
        check("L a_out c13", 32'(a_out), 32'd0);
        check("L hit c13", 32'(hit_cnt), 32'd0);
`endif
        start = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
